// File: rtl/multibyte_add_sequencer.sv
// Byte-serial W-bit adder sharing one 8-bit slice between two requesters.
// Round-robin arbitration in IDLE, one byte per cycle in ADD, result held in DONE.
module multibyte_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   res_sum,
    output logic                  res_cout,
    output logic                  res_id,
    output logic                  busy
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned BW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            last_grant;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic            any_valid_c;
    logic            grant_c;
    logic            accept_c;
    logic [BW-1:0]   base_c;
    logic [8:0]      slice_c;

    // Round-robin pick: on contention favour the requester not served last.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        grant_c     = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant;
        end
    end

    // Ready is combinational and only ever offered in IDLE, never during reset.
    assign accept_c   = (state == IDLE) && any_valid_c;
    assign req0_ready = !reset && accept_c && !grant_c;
    assign req1_ready = !reset && accept_c &&  grant_c;

    // The shared 8-bit slice operating on the current byte lane.
    assign base_c  = BW'({idx, 3'b000});
    assign slice_c = 9'(a_q[base_c +: 8]) + 9'(b_q[base_c +: 8]) + 9'(carry);

    // Sequencer: accept, ripple one byte per cycle, hold result until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_id     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid_c) begin
                        a_q    <= grant_c ? req1_a   : req0_a;
                        b_q    <= grant_c ? req1_b   : req0_b;
                        carry  <= grant_c ? req1_cin : req0_cin;
                        res_id <= grant_c;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    res_sum[base_c +: 8] <= slice_c[7:0];
                    carry                <= slice_c[8];
                    if (idx == LAST_IDX) begin
                        res_cout  <= slice_c[8];
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        last_grant <= res_id;
                        res_valid  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer: one NBYTES=4 and one NBYTES=1 instance.
module tb_multibyte_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  vld;          // index = inst*2 + requester
    logic [3:0]  rdy;
    logic [3:0]  rc;
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [7:0]  ra1 [2];
    logic [7:0]  rb1 [2];
    logic [1:0]  res_valid_v, res_ready_v, res_cout_v, res_id_v, busy_v;
    logic [31:0] sum4;
    logic [7:0]  sum1;

    int checks = 0;
    int errors = 0;

    multibyte_add_sequencer #(.NBYTES(4)) u4 (
        .clk(clk), .reset(reset),
        .req0_valid(vld[0]), .req0_ready(rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_cin(rc[0]),
        .req1_valid(vld[1]), .req1_ready(rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_cin(rc[1]),
        .res_valid(res_valid_v[0]), .res_ready(res_ready_v[0]), .res_sum(sum4),
        .res_cout(res_cout_v[0]), .res_id(res_id_v[0]), .busy(busy_v[0])
    );

    multibyte_add_sequencer #(.NBYTES(1)) u1 (
        .clk(clk), .reset(reset),
        .req0_valid(vld[2]), .req0_ready(rdy[2]), .req0_a(ra1[0]), .req0_b(rb1[0]), .req0_cin(rc[2]),
        .req1_valid(vld[3]), .req1_ready(rdy[3]), .req1_a(ra1[1]), .req1_b(rb1[1]), .req1_cin(rc[3]),
        .res_valid(res_valid_v[1]), .res_ready(res_ready_v[1]), .res_sum(sum1),
        .res_cout(res_cout_v[1]), .res_id(res_id_v[1]), .busy(busy_v[1])
    );

    typedef struct {
        int          inst;
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction: request, accept, latency, result, handshake.
    task automatic run_op(input vec_t v, input int num);
        int k;
        int n;
        int lat;
        logic [31:0] got;
        k = v.inst * 2 + (v.id ? 1 : 0);
        @(negedge clk);
        if (v.inst == 0) begin ra[v.id] = v.a; rb[v.id] = v.b; end
        else begin ra1[v.id] = v.a[7:0]; rb1[v.id] = v.b[7:0]; end
        rc[k]  = v.cin;
        vld[k] = 1'b1;
        #1;
        n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); #1; n++; end
        check($sformatf("v%0d ready", num), 64'(rdy[k]), 64'd1);
        @(posedge clk); #1;
        vld[k] = 1'b0;
        // operands change after accept; in-flight op must not see it
        if (v.inst == 0) begin ra[v.id] = ~v.a; rb[v.id] = ~v.b; end
        else begin ra1[v.id] = ~v.a[7:0]; rb1[v.id] = ~v.b[7:0]; end
        rc[k] = ~v.cin;
        lat = 1;
        while (!res_valid_v[v.inst] && lat < 20) begin @(posedge clk); #1; lat++; end
        check($sformatf("v%0d latency", num), 64'(lat), 64'((v.inst == 0 ? 4 : 1) + 1));
        got = (v.inst == 0) ? sum4 : {24'd0, sum1};
        check($sformatf("v%0d sum", num), 64'(got), 64'(v.sum));
        check($sformatf("v%0d cout", num), 64'(res_cout_v[v.inst]), 64'(v.cout));
        check($sformatf("v%0d id", num), 64'(res_id_v[v.inst]), 64'(v.id));
        check($sformatf("v%0d busy", num), 64'(busy_v[v.inst]), 64'd1);
        @(posedge clk); #1;
        check($sformatf("v%0d drop", num), 64'({res_valid_v[v.inst], busy_v[v.inst]}), 64'd0);
    endtask

    initial begin : main
        int n;
        int both;
        int cyc;
        int g [$];
        logic [31:0] held;

        // NBYTES=1 vectors
        tbl[0] = '{1, 1'b0, 32'd15,        32'd1,        1'b0, 32'd16,        1'b0};
        tbl[1] = '{1, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        tbl[2] = '{1, 1'b0, 32'h0000_0080, 32'h0000_007F, 1'b1, 32'h0000_0000, 1'b1};
        // NBYTES=4 vectors
        tbl[3] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        tbl[4] = '{0, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
        tbl[5] = '{0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        tbl[6] = '{0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        tbl[7] = '{0, 1'b0, 32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0};
        tbl[8] = '{0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        tbl[9] = '{0, 1'b0, 32'h7F7F_7F7F, 32'h0101_0101, 1'b0, 32'h8080_8080, 1'b0};

        reset = 1'b1;
        vld = '0; rc = '0;
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
        ra1[0] = '0; ra1[1] = '0; rb1[0] = '0; rb1[1] = '0;
        res_ready_v = 2'b11;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst outputs u4", 64'({res_valid_v[0], busy_v[0], res_cout_v[0], res_id_v[0], rdy[1:0]}), 64'd0);
        check("rst sum u4", 64'(sum4), 64'd0);
        check("rst outputs u1", 64'({res_valid_v[1], busy_v[1], res_cout_v[1], res_id_v[1], rdy[3:2], sum1}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < NVEC; i++) run_op(tbl[i], i);

        // Result back-pressure: hold res_ready low for 3 cycles in DONE
        @(negedge clk);
        res_ready_v[0] = 1'b0;
        ra[0] = 32'h0102_0304; rb[0] = 32'h1020_3040; rc[0] = 1'b0; vld[0] = 1'b1;
        #1;
        n = 0;
        while (!rdy[0] && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        n = 0;
        while (!res_valid_v[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("stall valid", 64'(res_valid_v[0]), 64'd1);
        held = sum4;
        check("stall sum", 64'(held), 64'h1122_3344);
        ra[1] = 32'h0000_000A; rb[1] = 32'h0000_0005; rc[1] = 1'b1; vld[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall c%0d hold", c),
                  64'({res_valid_v[0], busy_v[0], rdy[1:0], res_id_v[0], res_cout_v[0]}), 64'b110000);
            check($sformatf("stall c%0d sum", c), 64'(sum4), 64'h1122_3344);
        end
        @(negedge clk);
        res_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        check("post-stall idle", 64'({res_valid_v[0], busy_v[0]}), 64'd0);
        check("post-stall ready1", 64'(rdy[1:0]), 64'b10);
        @(posedge clk); #1;
        vld[1] = 1'b0;
        n = 0;
        while (!res_valid_v[0] && n < 20) begin @(posedge clk); #1; n++; end
        check("post-stall sum", 64'(sum4), 64'h0000_0010);
        check("post-stall id", 64'(res_id_v[0]), 64'd1);
        @(posedge clk); #1;

        // Reset pulsed during ADD at byte index 2
        @(negedge clk);
        ra[0] = 32'h1111_1111; rb[0] = 32'h2222_2222; rc[0] = 1'b0; vld[0] = 1'b1;
        #1;
        n = 0;
        while (!rdy[0] && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        ra[0] = 32'd1; rb[0] = 32'd2; rc[0] = 1'b0;
        ra[1] = 32'd3; rb[1] = 32'd4; rc[1] = 1'b0;
        vld[1:0] = 2'b11;
        reset = 1'b1;
        #1;
        check("mid-op reset outputs",
              64'({res_valid_v[0], busy_v[0], res_cout_v[0], res_id_v[0], rdy[1:0]}), 64'd0);
        check("mid-op reset sum", 64'(sum4), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Both requesters valid continuously: grants must alternate from req0
        both = 0;
        cyc  = 0;
        while (g.size() < 4 && cyc < 80) begin
            if (rdy[0] && rdy[1]) both++;
            if (rdy[0]) g.push_back(0);
            else if (rdy[1]) g.push_back(1);
            if (res_valid_v[0]) check("arb sum", 64'(sum4), res_id_v[0] ? 64'd7 : 64'd3);
            @(negedge clk); #1;
            cyc++;
        end
        vld[1:0] = 2'b00;
        n = 0;
        while ((busy_v[0] || res_valid_v[0]) && n < 30) begin
            if (res_valid_v[0]) check("arb sum", 64'(sum4), res_id_v[0] ? 64'd7 : 64'd3);
            @(negedge clk); #1;
            n++;
        end
        check("arb drained", 64'({busy_v[0], res_valid_v[0]}), 64'd0);
        check("arb grant count", 64'(g.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < g.size()) check($sformatf("arb grant %0d", i), 64'(g[i]), 64'(i % 2));
        end
        check("arb never both ready", 64'(both), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
